assoc_accum_argmax: RTL and testbench

- Downstream consumer of the 26-lane popcount stage of the sequential associative module.
- Each beat delivers one 5-bit overlap count per class for one hypervector segment. The block accumulates these counts per class across all segments of a query.
- After the last segment, it scans the accumulators sequentially and reports the winning class index and score through a valid/ready handshake.

---
 rtl/assoc_accum_argmax_pkg.sv | 23 ++
 rtl/assoc_accum_argmax_lane.sv | 39 +++
 rtl/assoc_accum_argmax.sv | 105 ++++++++++
 tb/tb_assoc_accum_argmax.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_accum_argmax_pkg.sv
// Shared defaults, state encoding and saturation helper for the
// associative accumulate / argmax stage.
package assoc_accum_argmax_pkg;

  localparam int DEF_NUM_CLASS = 26;
  localparam int DEF_CNT_W     = 5;
  localparam int DEF_ACC_W     = 12;
  localparam int DEF_IDX_W     = 5;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest value representable in a w-bit unsigned accumulator.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned SAT_MAX = sat_max(DEF_ACC_W);

endpackage

// File: rtl/assoc_accum_argmax_lane.sv
// One per-class accumulator: saturating unsigned add of an upstream count,
// synchronous clear between queries, asynchronous reset.
module sat_accum_lane
  import assoc_accum_argmax_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [ACC_W-1:0] o_acc
);

  localparam logic [ACC_W-1:0] L_SAT_MAX = ACC_W'(sat_max(ACC_W));

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;

  // One extra bit catches the carry so the result can clamp instead of wrapping.
  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(i_cnt);
  assign o_acc = r_acc;

  // Accumulator register: clear wins over add; they never coincide in practice.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every lane
    // samples the same pre-edge values regardless of evaluation order.
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum[ACC_W] ? L_SAT_MAX : w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/assoc_accum_argmax.sv
// Accumulates per-class overlap counts across the segments of a query,
// then scans the accumulators one class per cycle and reports the argmax
// (lowest index wins ties) through a valid/ready result port.
module assoc_accum_argmax
  import assoc_accum_argmax_pkg::*;
#(
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [NUM_CLASS*CNT_W-1:0] sim_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_class,
  output logic [ACC_W-1:0]           out_score
);

  localparam logic [IDX_W-1:0] L_LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_scan_idx;
  logic [IDX_W-1:0] r_best_idx;
  logic [ACC_W-1:0] r_best_val;

  logic [ACC_W-1:0] w_acc [NUM_CLASS];
  logic             w_accept;
  logic             w_clear;
  logic [ACC_W-1:0] w_cur;
  logic             w_take;
  logic [ACC_W-1:0] w_next_val;
  logic [IDX_W-1:0] w_next_idx;

  assign in_ready = (r_state == ACCUM);
  assign w_accept = in_valid && in_ready;
  assign w_clear  = (r_state == DONE) && out_valid && out_ready;

  for (genvar k = 0; k < NUM_CLASS; k++) begin : g_lane
    sat_accum_lane #(
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_accept),
      .i_clr (w_clear),
      .i_cnt (sim_in[k*CNT_W +: CNT_W]),
      .o_acc (w_acc[k])
    );
  end

  // Scan comparator: index 0 seeds the best unconditionally, later classes
  // replace it only when strictly larger so ties stay with the lower index.
  assign w_cur      = w_acc[r_scan_idx];
  assign w_take     = (r_scan_idx == '0) || (w_cur > r_best_val);
  assign w_next_val = w_take ? w_cur      : r_best_val;
  assign w_next_idx = w_take ? r_scan_idx : r_best_idx;

  // Control FSM with registered scan state and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ACCUM;
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_score  <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept && in_last) begin
            r_state    <= SCAN;
            r_scan_idx <= '0;
          end
        end
        SCAN: begin
          r_best_val <= w_next_val;
          r_best_idx <= w_next_idx;
          if (r_scan_idx == L_LAST_IDX) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            out_class <= w_next_idx;
            out_score <= w_next_val;
          end else begin
            r_scan_idx <= r_scan_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_accum_argmax.sv
// Directed self-checking bench for assoc_accum_argmax. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_assoc_accum_argmax;
  import assoc_accum_argmax_pkg::*;

  localparam int NC = DEF_NUM_CLASS;
  localparam int CW = DEF_CNT_W;
  localparam int AW = DEF_ACC_W;
  localparam int IW = DEF_IDX_W;
  localparam int SW = NC * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [SW-1:0] sim_in;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [AW-1:0] out_score;

  int n_checks = 0;
  int n_errors = 0;

  assoc_accum_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sim_in    (sim_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] lane(input logic [SW-1:0] v, input int k, input int val);
    v[k*CW +: CW] = CW'(val);
    return v;
  endfunction

  // Present one beat for exactly one clock; assumes caller is at a falling edge.
  task automatic beat(input logic [SW-1:0] v, input logic last);
    in_valid = 1'b1;
    sim_in   = v;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    sim_in   = '0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== '0 || out_score !== '0) begin
        $display("FAIL reset_idle cycle %0d: in_ready=%b out_valid=%b class=%0d score=%0d, want 1 0 0 0",
                 i, in_ready, out_valid, out_class, out_score);
        n_errors++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_beat();
    int cyc;
    beat(lane(lane('0, 7, 5), 20, 3), 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL single_ready_scan: got %b want 0", in_ready); n_errors++;
    end
    wait_result(cyc);
    n_checks++;
    if (cyc !== 26) begin
      $display("FAIL single_latency: got %0d want 26", cyc); n_errors++;
    end
    n_checks++;
    if (out_class !== 5'd7 || out_score !== 12'd5) begin
      $display("FAIL single_result: class=%0d score=%0d want 7 5", out_class, out_score); n_errors++;
    end
    accept();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL single_accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); n_errors++;
    end
  endtask

  task automatic test_multi_beat();
    int cyc;
    int c25 [4] = '{5, 5, 5, 2};
    for (int i = 0; i < 4; i++) beat(lane(lane('0, 3, 4), 25, c25[i]), i == 3);
    // Fifth beat offered while scanning must be refused.
    in_valid = 1'b1;
    in_last  = 1'b1;
    sim_in   = lane('0, 25, 31);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL multi_refuse cycle %0d: in_ready=%b want 0", i, in_ready); n_errors++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    sim_in   = '0;
    wait_result(cyc);
    n_checks++;
    if (cyc !== 23) begin
      $display("FAIL multi_latency: got %0d want 23", cyc); n_errors++;
    end
    n_checks++;
    if (out_class !== 5'd25 || out_score !== 12'd17) begin
      $display("FAIL multi_result: class=%0d score=%0d want 25 17", out_class, out_score); n_errors++;
    end
    accept();
  endtask

  task automatic test_tie();
    int cyc;
    beat(lane(lane(lane('0, 2, 5), 9, 5), 25, 9), 1'b0);
    beat(lane(lane(lane('0, 2, 5), 9, 5), 0, 3), 1'b1);
    wait_result(cyc);
    n_checks++;
    if (out_class !== 5'd2 || out_score !== 12'd10) begin
      $display("FAIL tie_result: class=%0d score=%0d want 2 10", out_class, out_score); n_errors++;
    end
    accept();
  endtask

  task automatic test_saturation();
    int cyc;
    for (int i = 0; i < 200; i++) beat('1, i == 199);
    wait_result(cyc);
    n_checks++;
    if (out_valid !== 1'b1 || out_class !== 5'd0 || out_score !== 12'd4095) begin
      $display("FAIL sat_result: valid=%b class=%0d score=%0d want 1 0 4095",
               out_valid, out_class, out_score); n_errors++;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== 5'd0 || out_score !== 12'd4095) begin
        $display("FAIL bp_hold cycle %0d: valid=%b in_ready=%b class=%0d score=%0d want 1 0 0 4095",
                 i, out_valid, in_ready, out_class, out_score); n_errors++;
      end
      @(negedge clk);
    end
    accept();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== 5'd0 || out_score !== 12'd4095) begin
      $display("FAIL bp_release: valid=%b in_ready=%b class=%0d score=%0d want 0 1 0 4095",
               out_valid, in_ready, out_class, out_score); n_errors++;
    end
    beat(lane('0, 4, 1), 1'b1);
    wait_result(cyc);
    n_checks++;
    if (out_class !== 5'd4 || out_score !== 12'd1) begin
      $display("FAIL bp_next_query: class=%0d score=%0d want 4 1", out_class, out_score); n_errors++;
    end
    accept();
  endtask

  task automatic test_reset_mid_scan();
    int  cyc;
    bit  seen = 1'b0;
    beat(lane('0, 5, 7), 1'b1);
    repeat (12) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL midrst_in_scan: in_ready=%b want 0", in_ready); n_errors++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL midrst_async: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); n_errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("FAIL midrst_no_result: out_valid pulsed=%b want 0", seen); n_errors++;
    end
    beat(lane('0, 1, 1), 1'b1);
    wait_result(cyc);
    n_checks++;
    if (cyc !== 26 || out_class !== 5'd1 || out_score !== 12'd1) begin
      $display("FAIL midrst_fresh: latency=%0d class=%0d score=%0d want 26 1 1",
               cyc, out_class, out_score); n_errors++;
    end
    accept();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sim_in    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_tie();
    test_saturation();
    test_backpressure();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
